fmesh_route_stage: RTL



---
 rtl/fmesh_route_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fmesh_route_stage.sv
// fmesh_route_stage: per-input-port route computation with a one-deep valid/ready flit register.
// Defining FMESH_ROUTE_STAGE_PKT_CNT_EN adds the pkt_cnt / err_cnt statistics outputs.
module fmesh_route_stage #(
    parameter int    NX         = 4,
    parameter int    NY         = 4,
    parameter int    NL         = 2,
    parameter int    EAw        = 7,
    parameter int    Fw         = 32,
    parameter int    PLw        = 3,
    parameter string ROUTE_TYPE = "DETERMINISTIC"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [$clog2(NX)-1:0] current_x,
    input  logic [$clog2(NY)-1:0] current_y,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_hdr,
    input  logic                  in_tail,
    input  logic [EAw-1:0]        in_dest_e_addr,
    input  logic [Fw-1:0]         in_flit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_hdr,
    output logic                  out_tail,
    output logic [Fw-1:0]         out_flit,
    output logic [3:0]            dest_port_coded,
    output logic [PLw-1:0]        endp_localp_num,
`ifdef FMESH_ROUTE_STAGE_PKT_CNT_EN
    output logic [15:0]           pkt_cnt,
    output logic [7:0]            err_cnt,
`endif
    output logic                  addr_err
);
    localparam int Xw = $clog2(NX);
    localparam int Yw = $clog2(NY);
    localparam int Pw = EAw - Xw - Yw;
    localparam bit ADAPTIVE = (ROUTE_TYPE == "FULL_ADAPTIVE");

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t           state_reg, state_next;
    logic             out_valid_reg, out_valid_next;
    logic             out_hdr_reg, out_hdr_next;
    logic             out_tail_reg, out_tail_next;
    logic [Fw-1:0]    out_flit_reg, out_flit_next;
    logic [3:0]       coded_reg, coded_next;
    logic [PLw-1:0]   localp_reg, localp_next;
    logic             addr_err_reg, addr_err_next;

    logic [Xw-1:0]    dx;
    logic [Yw-1:0]    dy;
    logic [Pw-1:0]    dp;
    logic [3:0]       edge_on;
    logic [3:0]       edge_bad;
    logic             range_bad, addr_bad;
    logic             x_diff, y_diff, route_b;
    logic [3:0]       route_coded;
    logic [PLw-1:0]   route_localp;
    logic             accept, err_event;

    assign dx = in_dest_e_addr[Xw-1:0];
    assign dy = in_dest_e_addr[Xw +: Yw];
    assign dp = in_dest_e_addr[Xw+Yw +: Pw];

    // Edge ports 1..4 are E/N/W/S; each must sit on its own mesh boundary.
    assign edge_on = {int'(dy) == NY - 1, dx == '0, dy == '0, int'(dx) == NX - 1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign edge_bad[gi] = (int'(dp) == gi + 1) && !edge_on[gi];
        end
        if (Pw >= PLw) begin : g_lp_trunc
            assign route_localp = dp[PLw-1:0];
        end else begin : g_lp_ext
            assign route_localp = {{(PLw - Pw){1'b0}}, dp};
        end
    endgenerate

    assign range_bad = (int'(dx) > NX - 1) || (int'(dy) > NY - 1) || (int'(dp) > 3 + NL);
    assign addr_bad  = range_bad || (|edge_bad);

    // XY order in deterministic mode: y is only resolved once x already matches.
    assign x_diff      = (dx != current_x);
    assign y_diff      = (dy != current_y);
    assign route_b     = y_diff && (ADAPTIVE || !x_diff);
    assign route_coded = {x_diff && (dx > current_x), route_b && (dy < current_y), x_diff, route_b};

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_hdr_next   = out_hdr_reg;
        out_tail_next  = out_tail_reg;
        out_flit_next  = out_flit_reg;
        coded_next     = coded_reg;
        localp_next    = localp_reg;
        addr_err_next  = addr_err_reg;
        err_event      = 1'b0;

        if (in_ready) begin
            out_valid_next = 1'b0;
        end
        if (accept) begin
            if (in_hdr || state_reg == IN_PKT) begin
                out_valid_next = 1'b1;
                out_hdr_next   = in_hdr;
                out_tail_next  = in_tail;
                out_flit_next  = in_flit;
                state_next     = in_tail ? IDLE : IN_PKT;
                if (in_hdr) begin
                    coded_next  = route_coded;
                    localp_next = route_localp;
                    err_event   = addr_bad || (state_reg == IN_PKT);
                end
            end else begin
                // Orphan body/tail with no open packet is discarded.
                err_event = 1'b1;
            end
        end
        if (err_event) begin
            addr_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_hdr_reg   <= 1'b0;
            out_tail_reg  <= 1'b0;
            out_flit_reg  <= '0;
            coded_reg     <= '0;
            localp_reg    <= '0;
            addr_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_hdr_reg   <= out_hdr_next;
            out_tail_reg  <= out_tail_next;
            out_flit_reg  <= out_flit_next;
            coded_reg     <= coded_next;
            localp_reg    <= localp_next;
            addr_err_reg  <= addr_err_next;
        end
    end

    assign out_valid       = out_valid_reg;
    assign out_hdr         = out_hdr_reg;
    assign out_tail        = out_tail_reg;
    assign out_flit        = out_flit_reg;
    assign dest_port_coded = coded_reg;
    assign endp_localp_num = localp_reg;
    assign addr_err        = addr_err_reg;

`ifdef FMESH_ROUTE_STAGE_PKT_CNT_EN
    logic [15:0] pkt_cnt_reg;
    logic [7:0]  err_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (accept && in_tail) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
            if (err_event && err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign pkt_cnt = pkt_cnt_reg;
    assign err_cnt = err_cnt_reg;
`endif
endmodule
